spm_bank_request_serializer: RTL
================================

Name: spm_bank_request_serializer

Overview:
- Request-side companion of the scratchpad read-return crossbar: accepts one vector request from the PE lanes, resolves bank conflicts, and issues at most one access per bank per cycle over as many rounds as conflicts require.
- For loads it produces, one cycle after each issue round, the per-lane bank-index vector and lane mask. These feed the read-return crossbar that maps bank output data back to lanes.
- Sits between the SPM request unit and the bank SRAM array.

Parameters:
LANES, `SM_PROCESSING_ELEMENTS (16), number of PE lanes
BANKS, `SM_MEMORY_BANKS (16), number of banks; power of two
BANK_W, $clog2(BANKS), bank index width
ENTRY_W, 10, per-bank entry address width
DATA_W, 32, lane and bank word width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  serializer idle and able to accept
req_is_store  in  1  1 = store, 0 = load
req_lane_mask  in  LANES  active lanes
req_address  in  LANES*(ENTRY_W+BANK_W)  per-lane word address; bank = low BANK_W bits, entry = upper ENTRY_W bits
req_store_data  in  LANES*DATA_W  per-lane store data
bank_valid  out  BANKS  bank access this cycle
bank_we  out  BANKS  write enable per bank
bank_entry  out  BANKS*ENTRY_W  entry address per bank
bank_wdata  out  BANKS*DATA_W  write data per bank
rd_valid  out  1  read-return vector valid (aligned with 1-cycle SRAM read data)
rd_bank_indexes  out  LANES*BANK_W  per-lane bank index for the read-return crossbar
rd_lane_mask  out  LANES  lanes served in this return round
rd_last  out  1  final return round of the request
done  out  1  one-cycle pulse, request fully issued
busy  out  1  state != IDLE

Behaviour:
- FSM has two states, IDLE and ISSUE. In reset, state = IDLE, the pending mask and all latched request fields are 0, and every output is 0 except req_ready = 1.
- req_ready = (state == IDLE). A handshake (req_valid & req_ready) latches is_store, lane mask (into pending), addresses and data, then moves to ISSUE. req_* is ignored otherwise.
- ISSUE, each cycle: for every bank b, the winner is the lowest-index pending lane whose bank field equals b (fixed priority).
  - bank_valid[b] = winner exists.
  - bank_entry and bank_wdata come from the winner.
  - bank_we[b] = bank_valid[b] & is_store.
  - bank_* outputs are combinational from registered state only.
- Winning lanes are cleared from pending at the clock edge.
- When the next pending value is 0, the FSM goes to IDLE and done pulses on the following cycle, together with rd_last for loads.
- Latency:
  - First bank access occurs 1 cycle after acceptance.
  - A request whose worst bank holds k lanes takes k ISSUE cycles.
  - The next request can be accepted the cycle done pulses.
- Read return, loads only: registered one cycle after each ISSUE round.
  - rd_valid = 1.
  - rd_lane_mask = lanes won in that round.
  - rd_bank_indexes = latched bank fields of all lanes (unmasked lanes don't-care but deterministic).
  - rd_last = 1 on the final round.
  - Stores never assert rd_valid.
- Empty lane mask: accepted, one ISSUE cycle with no bank_valid, done pulses, no rd_valid.
- Banks are always ready; there is no backpressure.
- Reset asserted mid-request drops the request immediately. No done is produced and outputs go to reset values.
- Width rule: bank/entry split is pure bit slicing; no address arithmetic.

Optional Feature:
- Macro SPM_SERIALIZER_BROADCAST_EN.
- Defined, loads only: all pending lanes with the same bank and the same entry as the bank's winner are served in the same round. All of them are cleared and set in rd_lane_mask.
- Stores are unaffected; same-address stores are still serialized in lane order, so the highest lane writes last.
- Undefined: strict one-lane-per-bank-per-round.

Decomposition:
- Shared package npu_spm_defines: sm_bank_address_t, sm_entry_address_t, sm_data_t, the lane/bank counts, and a packed sm_lane_address_t struct {entry, bank}.
- One sub-module, spm_bank_priority_picker: combinational. Per bank it returns a winner one-hot and a valid from the pending mask and bank fields; it is instantiated once and generated across BANKS.

Test Plan:
- Load, mask 0xFFFF, lane i -> bank i, entry 5: one ISSUE cycle with bank_valid = 0xFFFF, all entries 5. Next cycle rd_valid = 1, rd_lane_mask = 0xFFFF, rd_last = 1, done = 1.
- Load, all 16 lanes -> bank 3, distinct entries: 16 cycles of bank_valid = 0x0008, lanes served in order 0..15. rd_lane_mask walks 0x0001..0x8000; rd_last only on the 16th; req_ready low throughout.
- Store, lanes 0,4 -> bank 2, lane 1 -> bank 7, data = lane id: cycle 1 banks {2,7} write data {0,1}, cycle 2 bank 2 writes 4. bank_we = bank_valid, no rd_valid, done after cycle 2.
- Mask 0x0000, req_valid: accepted, no bank_valid, done pulses 2 cycles after acceptance, req_ready high again.
- Same-bank load conflict (4 lanes to bank 3), reset low during cycle 2: outputs cleared asynchronously, no done. After release req_ready = 1 and a new request completes normally.
- SPM_SERIALIZER_BROADCAST_EN, load, all lanes -> bank 0, entry 9: single round, rd_lane_mask = 0xFFFF. Without the macro, 16 rounds.

Source files
------------

// File: rtl/spm_bank_request_serializer_pkg.sv
// Shared scratchpad definitions: lane/bank counts, address field types and serializer FSM states.
`ifndef SM_PROCESSING_ELEMENTS
`define SM_PROCESSING_ELEMENTS 16
`endif
`ifndef SM_MEMORY_BANKS
`define SM_MEMORY_BANKS 16
`endif

package npu_spm_defines;

   localparam int SM_LANES   = `SM_PROCESSING_ELEMENTS;
   localparam int SM_BANKS   = `SM_MEMORY_BANKS;
   localparam int SM_BANK_W  = $clog2(SM_BANKS);
   localparam int SM_ENTRY_W = 10;
   localparam int SM_DATA_W  = 32;

   typedef logic [SM_BANK_W-1:0]  sm_bank_address_t;
   typedef logic [SM_ENTRY_W-1:0] sm_entry_address_t;
   typedef logic [SM_DATA_W-1:0]  sm_data_t;

   // Lane word address: the bank is the low bits so consecutive words stripe across banks.
   typedef struct packed {
      sm_entry_address_t entry;
      sm_bank_address_t  bank;
   } sm_lane_address_t;

   typedef enum logic {
      SER_IDLE  = 1'b0,
      SER_ISSUE = 1'b1
   } ser_state_t;

endpackage

// File: rtl/spm_bank_request_serializer_picker.sv
// Per-bank fixed-priority picker: lowest-index pending lane targeting BANK_ID wins.
// With SPM_SERIALIZER_BROADCAST_EN, load lanes sharing the winner's entry are served alongside it.
module spm_bank_priority_picker
   import npu_spm_defines::*;
#(
   parameter int LANES   = SM_LANES,
   parameter int BANK_W  = SM_BANK_W,
   parameter int ENTRY_W = SM_ENTRY_W,
   parameter int BANK_ID = 0
)(
   input  logic [LANES-1:0]         pending,
   input  logic [LANES*BANK_W-1:0]  lane_bank,
`ifdef SPM_SERIALIZER_BROADCAST_EN
   input  logic [LANES*ENTRY_W-1:0] lane_entry,
   input  logic                     is_store,
`endif
   output logic                     win_valid,
   output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] win_idx,
   output logic [LANES-1:0]         served
);

   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [BANK_W-1:0] MY_BANK = BANK_ID[BANK_W-1:0];

   logic [LANES-1:0] hit;

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hit       = '0;
      win_valid = 1'b0;
      win_idx   = '0;
      served    = '0;
      for (int l = 0; l < LANES; l++)
         hit[l] = pending[l] && (lane_bank[l*BANK_W +: BANK_W] == MY_BANK);
      // Scan downwards so the lowest matching lane is the last one written.
      for (int l = LANES - 1; l >= 0; l--) begin
         if (hit[l]) begin
            win_valid = 1'b1;
            win_idx   = LANE_W'(l);
         end
      end
      served[win_idx] = win_valid;
`ifdef SPM_SERIALIZER_BROADCAST_EN
      if (win_valid && !is_store) begin
         for (int l = 0; l < LANES; l++)
            if (hit[l] && (lane_entry[l*ENTRY_W +: ENTRY_W] == lane_entry[win_idx*ENTRY_W +: ENTRY_W]))
               served[l] = 1'b1;
      end
`endif
   end

endmodule

// File: rtl/spm_bank_request_serializer.sv
// Scratchpad bank request serializer: splits one vector request into conflict-free bank rounds
// and emits the read-return steering vector for loads. Optional: SPM_SERIALIZER_BROADCAST_EN.
module spm_bank_request_serializer
   import npu_spm_defines::*;
#(
   parameter int LANES   = SM_LANES,
   parameter int BANKS   = SM_BANKS,
   parameter int ENTRY_W = SM_ENTRY_W,
   parameter int DATA_W  = SM_DATA_W
)(
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 req_valid,
   output logic                                 req_ready,
   input  logic                                 req_is_store,
   input  logic [LANES-1:0]                     req_lane_mask,
   input  logic [LANES*(ENTRY_W+$clog2(BANKS))-1:0] req_address,
   input  logic [LANES*DATA_W-1:0]              req_store_data,
   output logic [BANKS-1:0]                     bank_valid,
   output logic [BANKS-1:0]                     bank_we,
   output logic [BANKS*ENTRY_W-1:0]             bank_entry,
   output logic [BANKS*DATA_W-1:0]              bank_wdata,
   output logic                                 rd_valid,
   output logic [LANES*$clog2(BANKS)-1:0]       rd_bank_indexes,
   output logic [LANES-1:0]                     rd_lane_mask,
   output logic                                 rd_last,
   output logic                                 done,
   output logic                                 busy
);

   localparam int BANK_W = $clog2(BANKS);
   localparam int ADDR_W = ENTRY_W + BANK_W;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   ser_state_t                state_q, state_d;
   logic                      is_store_q;
   logic [LANES-1:0]          pending_q, pending_next, served_all;
   logic [LANES*ADDR_W-1:0]   addr_q;
   logic [LANES*DATA_W-1:0]   data_q;
   logic [LANES*BANK_W-1:0]   lane_bank;
   logic [LANES*ENTRY_W-1:0]  lane_entry;
   logic [BANKS-1:0]          win_valid;
   logic [LANE_W-1:0]         win_idx [BANKS];
   logic [LANES-1:0]          served  [BANKS];
   logic                      issue, accept, rd_round;

   for (genvar l = 0; l < LANES; l++) begin : g_split
      assign lane_bank[l*BANK_W +: BANK_W]   = addr_q[l*ADDR_W +: BANK_W];
      assign lane_entry[l*ENTRY_W +: ENTRY_W] = addr_q[l*ADDR_W + BANK_W +: ENTRY_W];
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      spm_bank_priority_picker #(
         .LANES   (LANES),
         .BANK_W  (BANK_W),
         .ENTRY_W (ENTRY_W),
         .BANK_ID (b)
      ) u_picker (
         .pending    (pending_q),
         .lane_bank  (lane_bank),
`ifdef SPM_SERIALIZER_BROADCAST_EN
         .lane_entry (lane_entry),
         .is_store   (is_store_q),
`endif
         .win_valid  (win_valid[b]),
         .win_idx    (win_idx[b]),
         .served     (served[b])
      );
   end

   assign issue    = (state_q == SER_ISSUE);
   assign accept   = req_valid && req_ready;
   assign rd_round = issue && !is_store_q && (pending_q != '0);

   always_comb begin
      served_all = '0;
      for (int b = 0; b < BANKS; b++)
         served_all |= served[b];
      pending_next = pending_q & ~served_all;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      busy      = 1'b0;
      case (state_q)
         SER_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_d = SER_ISSUE;
         end
         SER_ISSUE: begin
            busy = 1'b1;
            if (pending_next == '0)
               state_d = SER_IDLE;
         end
         default: state_d = SER_IDLE;
      endcase
   end

   // Bank ports depend only on registered request state, so the SRAM sees a clean launch.
   always_comb begin
      bank_valid = win_valid & {BANKS{issue}};
      bank_we    = bank_valid & {BANKS{is_store_q}};
      bank_entry = '0;
      bank_wdata = '0;
      for (int b = 0; b < BANKS; b++) begin
         if (bank_valid[b]) begin
            bank_entry[b*ENTRY_W +: ENTRY_W] = lane_entry[win_idx[b]*ENTRY_W +: ENTRY_W];
            bank_wdata[b*DATA_W +: DATA_W]   = data_q[win_idx[b]*DATA_W +: DATA_W];
         end
      end
   end

   // NOTE: the wide request registers are reset too, so a dropped request leaves no stale fields behind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= SER_IDLE;
         is_store_q      <= 1'b0;
         pending_q       <= '0;
         addr_q          <= '0;
         data_q          <= '0;
         done            <= 1'b0;
         rd_valid        <= 1'b0;
         rd_lane_mask    <= '0;
         rd_bank_indexes <= '0;
         rd_last         <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            is_store_q <= req_is_store;
            pending_q  <= req_lane_mask;
            addr_q     <= req_address;
            data_q     <= req_store_data;
         end else if (issue) begin
            pending_q <= pending_next;
         end
         done            <= issue && (pending_next == '0);
         rd_valid        <= rd_round;
         rd_lane_mask    <= rd_round ? served_all : '0;
         rd_bank_indexes <= rd_round ? lane_bank : '0;
         rd_last         <= rd_round && (pending_next == '0);
      end
   end

endmodule
